// File: rtl/cla_mul_seq_pkg.sv
// Shared types and constants for the sequential CLA multiplier.
// Holds the FSM state encoding, iteration/latency constants and CLA bundle.
package cla_mul_seq_pkg;

  localparam int XLEN        = 32;
  localparam int MUL_ITERS   = 32;
  localparam int MUL_LATENCY = 36;
  localparam int CNT_W       = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NEG_A  = 3'd1,
    ST_NEG_B  = 3'd2,
    ST_MUL    = 3'd3,
    ST_FIX_LO = 3'd4,
    ST_FIX_HI = 3'd5
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic            cin;
  } cla_in_t;

endpackage

// File: rtl/cla_mul_seq_if.sv
// Start/busy/done handshake and operand/result bus of the multiplier.
// master drives iStart/iSigned/iA/iB; slave drives oBusy/oDone/oHi/oLo.
interface cla_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             iStart;
  logic             iSigned;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oBusy;
  logic             oDone;
  logic [WIDTH-1:0] oHi;
  logic [WIDTH-1:0] oLo;

  modport master (
    output iStart, iSigned, iA, iB,
    input  oBusy, oDone, oHi, oLo
  );

  modport slave (
    input  iStart, iSigned, iA, iB,
    output oBusy, oDone, oHi, oLo
  );
endinterface

// File: rtl/cla_mul_seq_cla.sv
// Single-cycle carry-lookahead adder, 4-bit lookahead groups.
// Ports: iX/iY/iCarry in; oS, oCarry, oOverflow, oZero, oNegative out.
module cla_mul_seq_cla #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] iX,
  input  logic [WIDTH-1:0] iY,
  input  logic             iCarry,
  output logic [WIDTH-1:0] oS,
  output logic             oCarry,
  output logic             oOverflow,
  output logic             oZero,
  output logic             oNegative
);

  localparam int NGRP = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  assign g = iX & iY;
  assign p = iX ^ iY;

  // Carries inside a group are fully expanded from the group carry-in;
  // the group carry-out uses group generate/propagate.
  always_comb begin
    c = '0;
    c[0] = iCarry;
    for (int k = 0; k < NGRP; k++) begin
      c[4*k+1] = g[4*k]
               | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k]
                  & c[4*k]);
      c[4*k+4] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1]
                  & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1]
                  & p[4*k] & c[4*k]);
    end
  end

  assign oS        = p ^ c[WIDTH-1:0];
  assign oCarry    = c[WIDTH];
  assign oOverflow = c[WIDTH] ^ c[WIDTH-1];
  assign oZero     = (oS == '0);
  assign oNegative = oS[WIDTH-1];

endmodule

// File: rtl/cla_mul_seq.sv
// Iterative 32x32->64 shift-add multiplier built around one CLA.
// Ports: iClk, iRst (sync, active-high), bus (slave: start/operands, busy/done/HI/LO).
module cla_mul_seq
  import cla_mul_seq_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic         iClk,
  input  logic         iRst,
  cla_mul_seq_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic             sgn_q, sgn_d;
  logic             neg_q, neg_d;
  logic             c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  cla_in_t          cla_in;
  logic [WIDTH-1:0] cla_s;
  logic             cla_co;
  logic             unused_ovf;
  logic             unused_zero;
  logic             unused_neg;

  cla_mul_seq_cla #(
    .WIDTH(WIDTH)
  ) u_cla (
    .iX       (cla_in.x),
    .iY       (cla_in.y),
    .iCarry   (cla_in.cin),
    .oS       (cla_s),
    .oCarry   (cla_co),
    .oOverflow(unused_ovf),
    .oZero    (unused_zero),
    .oNegative(unused_neg)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      sgn_q   <= sgn_d;
      neg_q   <= neg_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // A is parked in M and B in P_lo on accept; the NEG states
  // then replace them in place by their magnitudes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    sgn_d   = sgn_q;
    neg_d   = neg_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cla_in  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          m_d     = bus.iA;
          p_lo_d  = bus.iB;
          sgn_d   = bus.iSigned & SIGNED_EN;
          neg_d   = sgn_d
                  & (bus.iA[WIDTH-1] ^ bus.iB[WIDTH-1]);
          busy_d  = 1'b1;
          state_d = ST_NEG_A;
        end
      end
      ST_NEG_A: begin
        cla_in.x   = ~m_q;
        cla_in.cin = 1'b1;
        if (sgn_q & m_q[WIDTH-1]) begin
          m_d = cla_s;
        end
        state_d = ST_NEG_B;
      end
      ST_NEG_B: begin
        cla_in.x   = ~p_lo_q;
        cla_in.cin = 1'b1;
        if (sgn_q & p_lo_q[WIDTH-1]) begin
          p_lo_d = cla_s;
        end
        p_hi_d  = '0;
        cnt_d   = '0;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        cla_in.x = p_hi_q;
        cla_in.y = p_lo_q[0] ? m_q : '0;
        // 65-bit {carry,sum,P_lo} shifted right by one
        p_hi_d = {cla_co, cla_s[WIDTH-1:1]};
        p_lo_d = {cla_s[0], p_lo_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
          state_d = ST_FIX_LO;
        end
      end
      ST_FIX_LO: begin
        cla_in.x   = ~p_lo_q;
        cla_in.cin = 1'b1;
        if (neg_q) begin
          p_lo_d = cla_s;
          c_d    = cla_co;
        end else begin
          c_d = 1'b0;
        end
        state_d = ST_FIX_HI;
      end
      ST_FIX_HI: begin
        cla_in.x   = ~p_hi_q;
        cla_in.cin = c_q;
        hi_d    = neg_q ? cla_s : p_hi_q;
        lo_d    = p_lo_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.oBusy = busy_q;
  assign bus.oDone = done_q;
  assign bus.oHi   = hi_q;
  assign bus.oLo   = lo_q;

endmodule

// File: tb/tb_cla_mul_seq.sv
// Directed plus random checks of cla_mul_seq against a 64-bit product model.
// Drives and samples on the falling edge; counts vectors and miscompares.
module tb_cla_mul_seq;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  cla_mul_seq_if #(.WIDTH(32)) bus ();

  cla_mul_seq #(
    .WIDTH    (32),
    .SIGNED_EN(1'b1)
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    longint sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // called at a falling edge; returns one falling edge after accept
  task automatic start_op(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    bus.iStart  = 1'b1;
    bus.iA      = a;
    bus.iB      = b;
    bus.iSigned = s;
    @(negedge clk);
    bus.iStart  = 1'b0;
    bus.iA      = $urandom;
    bus.iB      = $urandom;
    bus.iSigned = 1'($urandom);
  endtask

  task automatic wait_done(
    input  int c0,
    output int cyc
  );
    cyc = c0;
    while (bus.oDone !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(
    input string       tag,
    input int          cyc,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    logic [63:0] e;
    e = ref_mul(a, b, s);
    chk({tag, "_lat"}, 64'(cyc), 64'd36);
    chk({tag, "_hi"}, 64'(bus.oHi), 64'(e[63:32]));
    chk({tag, "_lo"}, 64'(bus.oLo), 64'(e[31:0]));
    chk({tag, "_busy"}, 64'(bus.oBusy), 64'd0);
  endtask

  task automatic do_op(
    input string       tag,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        s
  );
    int cyc;
    start_op(a, b, s);
    wait_done(0, cyc);
    check_result(tag, cyc, a, b, s);
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(bus.oDone), 64'd0);
  endtask

  initial begin
    int          cyc;
    logic [31:0] ra, rb;
    logic        rs;
    logic        seen;
    logic [31:0] hold_hi, hold_lo;
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    bus.iStart  = 1'b0;
    bus.iSigned = 1'b0;
    bus.iA      = '0;
    bus.iB      = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.oBusy), 64'd0);
    chk("rst_done", 64'(bus.oDone), 64'd0);
    chk("rst_hi", 64'(bus.oHi), 64'd0);
    chk("rst_lo", 64'(bus.oLo), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op("u5x10", 32'd5, 32'd10, 1'b0);
    do_op("uffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op("sm3x7", 32'hFFFF_FFFD, 32'd7, 1'b1);
    do_op("um3x7", 32'hFFFF_FFFD, 32'd7, 1'b0);
    do_op("sminmin", 32'h8000_0000, 32'h8000_0000, 1'b1);
    do_op("smin1", 32'h8000_0000, 32'd1, 1'b1);
    do_op("s7xm3", 32'd7, 32'hFFFF_FFFD, 1'b1);
    do_op("s0xm1", 32'd0, 32'hFFFF_FFFF, 1'b1);

    // results persist across a new start until completion
    hold_hi = bus.oHi;
    hold_lo = bus.oLo;
    do_op("pre", 32'd123456, 32'd789, 1'b0);
    hold_hi = bus.oHi;
    hold_lo = bus.oLo;
    start_op(32'd1000, 32'd3, 1'b0);
    chk("hold_hi", 64'(bus.oHi), 64'(hold_hi));
    chk("hold_lo", 64'(bus.oLo), 64'(hold_lo));
    chk("busy_on", 64'(bus.oBusy), 64'd1);

    // start while busy is ignored
    repeat (10) @(negedge clk);
    bus.iStart = 1'b1;
    bus.iA     = 32'd77;
    bus.iB     = 32'd99;
    @(negedge clk);
    bus.iStart = 1'b0;
    wait_done(11, cyc);
    check_result("ign", cyc, 32'd1000, 32'd3, 1'b0);

    // back-to-back start during the done cycle
    start_op(32'hFFFF_FFF0, 32'd16, 1'b1);
    chk("b2b_busy", 64'(bus.oBusy), 64'd1);
    chk("b2b_done", 64'(bus.oDone), 64'd0);
    wait_done(0, cyc);
    check_result("b2b", cyc, 32'hFFFF_FFF0,
                 32'd16, 1'b1);
    @(negedge clk);

    // reset mid-operation aborts with no result
    start_op(32'd12345, 32'd6789, 1'b0);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 64'(bus.oBusy), 64'd0);
    chk("abort_done", 64'(bus.oDone), 64'd0);
    chk("abort_hi", 64'(bus.oHi), 64'd0);
    chk("abort_lo", 64'(bus.oLo), 64'd0);
    seen = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (bus.oDone === 1'b1 || bus.oBusy === 1'b1)
        seen = 1'b1;
    end
    chk("abort_quiet", 64'(seen), 64'd0);
    do_op("u400x33", 32'd400, 32'd33, 1'b0);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i % 6 == 0) ra = 32'h8000_0000;
      if (i % 8 == 1) rb = 32'hFFFF_FFFF;
      do_op($sformatf("rnd%0d", i), ra, rb, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
